// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   NUM_DIGITS_DEF : default number of scanned digits
//   MAX_DIGITS     : widest anode vector the helper function can produce
//   AN_OFF         : all anodes off (active-low, so all ones)
//   onehot_n()     : active-low one-hot anode pattern for a digit index
package seven_seg_pkg;

    localparam int NUM_DIGITS_DEF = 4;
    localparam int MAX_DIGITS     = 16;

    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    function automatic logic [MAX_DIGITS-1:0] onehot_n(input logic [3:0] idx);
        logic [MAX_DIGITS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return ~oh;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_tick.sv
// Prescaler producing one tick per digit slot.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   enable : 1 = count, 0 = hold prescaler value
//   tick   : high for the last cycle of each slot while enabled
module scan_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int              PW   = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] prescaler;

    assign tick = enable && (prescaler == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (enable) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed scan driver for a common-anode multi-digit display.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   enable       : 1 = scan running, 0 = display dark and scan frozen
//   load         : 1-cycle strobe capturing value into the pending register
//   value        : hex value to show, nibble 0 = rightmost digit
//   blank_lz     : 1 = blank leading zero digits (digit 0 never blanked)
//   digit_nibble : nibble of the active digit, to the segment decoder
//   an_n         : active-low anode enables, at most one bit low
//   frame_done   : 1-cycle pulse when the scan wraps back to digit 0
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int CLK_DIV    = 50000,
    parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    output logic [3:0]              digit_nibble,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int                  VW       = 4 * NUM_DIGITS;
    localparam int                  IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0]       LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF_L = AN_OFF[NUM_DIGITS-1:0];

    logic                  tick;
    logic [IW-1:0]         idx, idx_next;
    // Cleared by reset: the first tick lights digit 0 instead of advancing,
    // so the display stays dark until one full slot has elapsed.
    logic                  started, started_next;
    logic [VW-1:0]         disp, disp_next, pending;
    logic                  pend_v;
    logic                  wrap, commit, blank, zero_run;
    logic [3:0]            nib_next;
    logic [MAX_DIGITS-1:0] an_full;
    logic [NUM_DIGITS-1:0] an_sel;

    scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    always_comb begin
        wrap         = tick && started && (idx == LAST_IDX);
        commit       = wrap && pend_v;
        started_next = started | tick;

        idx_next = idx;
        if (tick && started) begin
            idx_next = wrap ? '0 : idx + 1'b1;
        end

        // Outputs on the commit edge already reflect the new frame value.
        disp_next = commit ? pending : disp;

        nib_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_next == IW'(i)) nib_next = disp_next[4*i +: 4];
        end

        // Walk down from the top digit; a digit is a leading zero while every
        // nibble from it upward is zero. Digit 0 is never considered.
        blank    = 1'b0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (disp_next[4*i +: 4] == 4'h0);
            if ((idx_next == IW'(i)) && zero_run) blank = blank_lz;
        end

        an_full = onehot_n(4'(idx_next));
        an_sel  = an_full[NUM_DIGITS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            started      <= 1'b0;
            disp         <= '0;
            pending      <= '0;
            pend_v       <= 1'b0;
            digit_nibble <= 4'h0;
            an_n         <= AN_OFF_L;
            frame_done   <= 1'b0;
        end else begin
            idx     <= idx_next;
            started <= started_next;

            if (commit) begin
                disp   <= pending;
                pend_v <= 1'b0;
            end
            // A load on the commit edge becomes pending for the next frame.
            if (load) begin
                pending <= value;
                pend_v  <= 1'b1;
            end

            if (enable) begin
                digit_nibble <= nib_next;
                an_n         <= (started_next && !blank) ? an_sel : AN_OFF_L;
                frame_done   <= wrap;
            end else begin
                an_n       <= AN_OFF_L;
                frame_done <= 1'b0;
            end
        end
    end

endmodule
